seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for an N-digit 7-segment display.

---
 rtl/seg_scan_ctrl_pkg.sv | 13 +
 rtl/seg_lz_mask.sv | 26 ++
 rtl/seg_scan_ctrl.sv | 142 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller:
// scan-state encoding and nibble width.
package seg_scan_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_GUARD = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_e;

endpackage

// File: rtl/seg_lz_mask.sv
// Leading-zero blank mask: bit k is set when digit k and every more
// significant digit are zero. Digit 0 is never blanked.
module seg_lz_mask
    import seg_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic [NUM_DIGITS*NIBBLE_W-1:0] digits,
    input  logic                           lz_blank_en,
    output logic [NUM_DIGITS-1:0]          mask
);

    logic zero_run;

    // NOTE: combinational logic uses blocking '=' so zero_run carries from one
    // loop iteration to the next; every variable gets a default first so no latch forms.
    always_comb begin
        mask     = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run && (digits[k*NIBBLE_W +: NIBBLE_W] == '0);
            mask[k]  = lz_blank_en && zero_run;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed N-digit 7-segment scan controller with a double-buffered
// frame, anti-ghost guard interval and leading-zero blanking.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    input  logic                           load,
    input  logic [NUM_DIGITS*NIBBLE_W-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]          dp_in,
    input  logic                           lz_blank_en,
    output logic [NIBBLE_W-1:0]            bcd_out,
    output logic                           blank,
    output logic                           dp_out,
    output logic [NUM_DIGITS-1:0]          an_n,
    output logic                           frame_done
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]      GUARD_CNT = CNT_W'(GUARD);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = '1;

    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;

    logic [NUM_DIGITS-1:0][NIBBLE_W-1:0] display_digits;
    logic [NUM_DIGITS-1:0][NIBBLE_W-1:0] shadow_digits;
    logic [NUM_DIGITS-1:0]               display_dp;
    logic [NUM_DIGITS-1:0]               shadow_dp;
    logic                                pending;

    logic                  slot_end;
    logic                  frame_end;
    scan_state_e           state;
    logic [NIBBLE_W-1:0]   cur_nibble;
    logic                  cur_dp;
    logic [NUM_DIGITS-1:0] an_sel;
    logic [NUM_DIGITS-1:0] lz_mask;

    assign slot_end   = enable && (cnt == CNT_LAST);
    assign frame_end  = slot_end && (idx == IDX_LAST);
    assign cur_nibble = display_digits[idx];
    assign cur_dp     = display_dp[idx];
    assign an_sel     = ~(NUM_DIGITS'(1) << idx);

    always_comb begin
        state = ST_SHOW;
        if (!enable) begin
            state = ST_OFF;
        end else if (cnt < GUARD_CNT) begin
            state = ST_GUARD;
        end
    end

    seg_lz_mask #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_lz_mask (
        .digits      (display_digits),
        .lz_blank_en (lz_blank_en),
        .mask        (lz_mask)
    );

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (enable) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // NOTE: the frame buffers are flops, not RAM, so they take the async reset
    // and the display powers up with a defined all-zero frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display_digits <= '0;
            display_dp     <= '0;
            shadow_digits  <= '0;
            shadow_dp      <= '0;
            pending        <= 1'b0;
        end else begin
            if (load) begin
                shadow_digits <= digits_in;
                shadow_dp     <= dp_in;
            end
            // A load landing on the boundary cycle bypasses the shadow: newest wins.
            if (frame_end && load) begin
                display_digits <= digits_in;
                display_dp     <= dp_in;
                pending        <= 1'b0;
            end else if (frame_end && pending) begin
                display_digits <= shadow_digits;
                display_dp     <= shadow_dp;
                pending        <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_out    <= '0;
            blank      <= 1'b1;
            dp_out     <= 1'b0;
            an_n       <= AN_OFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            bcd_out    <= cur_nibble;
            case (state)
                ST_SHOW: begin
                    an_n   <= an_sel;
                    blank  <= lz_mask[idx];
                    dp_out <= cur_dp;
                end
                default: begin
                    an_n   <= AN_OFF;
                    blank  <= 1'b1;
                    dp_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl with 4 digits, 4-cycle slots
// and a 1-cycle guard, so one frame is 16 clocks.
module tb_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int GD = 1;
    localparam int FRAME = ND * RD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic        lz_blank_en = 1'b0;
    logic [3:0]  bcd_out;
    logic        blank;
    logic        dp_out;
    logic [3:0]  an_n;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] obs_an    [FRAME];
    logic [3:0] obs_bcd   [FRAME];
    logic       obs_blank [FRAME];
    logic       obs_dp    [FRAME];
    logic       obs_fd    [FRAME];

    seg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .GUARD       (GD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .load        (load),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .lz_blank_en (lz_blank_en),
        .bcd_out     (bcd_out),
        .blank       (blank),
        .dp_out      (dp_out),
        .an_n        (an_n),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    // Expected anode pattern for frame cycle i: guard cycle dark, else digit i/RD low.
    function automatic logic [3:0] exp_an(input int i);
        logic [3:0] one;
        one = 4'b0001;
        if ((i % RD) < GD) return 4'b1111;
        return ~(one << (i / RD));
    endfunction

    function automatic logic [3:0] nib(input logic [15:0] v, input int d);
        logic [15:0] t;
        t = v >> (4 * d);
        return t[3:0];
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one aligned frame, optionally pulsing load at up to two cycles,
    // and records the outputs seen after each clock.
    task automatic scan_frame(input int la, input logic [15:0] va,
                              input int lb, input logic [15:0] vb);
        for (int i = 0; i < FRAME; i++) begin
            if (i == la) begin
                load = 1'b1; digits_in = va;
            end else if (i == lb) begin
                load = 1'b1; digits_in = vb;
            end else begin
                load = 1'b0;
            end
            step();
            obs_an[i]    = an_n;
            obs_bcd[i]   = bcd_out;
            obs_blank[i] = blank;
            obs_dp[i]    = dp_out;
            obs_fd[i]    = frame_done;
        end
        load = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (an_n !== 4'b1111) begin n_fail++; $display("FAIL reset_an: got %b expected 1111", an_n); end
        n_checks++; if (bcd_out !== 4'h0) begin n_fail++; $display("FAIL reset_bcd: got %h expected 0", bcd_out); end
        n_checks++; if (blank !== 1'b1) begin n_fail++; $display("FAIL reset_blank: got %b expected 1", blank); end
        n_checks++; if (dp_out !== 1'b0) begin n_fail++; $display("FAIL reset_dp: got %b expected 0", dp_out); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %b expected 0", frame_done); end
        rst_n = 1'b1;
        step();
        n_checks++; if (an_n !== 4'b1111 || blank !== 1'b1) begin n_fail++; $display("FAIL off_after_reset: an=%b blank=%b expected 1111/1", an_n, blank); end
    endtask

    task automatic test_scan();
        logic [15:0] v;
        v = 16'h1234;
        enable = 1'b1;
        scan_frame(0, v, -1, 16'h0);
        for (int i = 0; i < FRAME; i++) begin
            n_checks++; if (obs_fd[i] !== (i == FRAME - 1)) begin n_fail++; $display("FAIL scan_fd0[%0d]: got %b expected %b", i, obs_fd[i], (i == FRAME - 1)); end
        end
        scan_frame(-1, 16'h0, -1, 16'h0);
        for (int i = 0; i < FRAME; i++) begin
            n_checks++; if (obs_an[i] !== exp_an(i)) begin n_fail++; $display("FAIL scan_an[%0d]: got %b expected %b", i, obs_an[i], exp_an(i)); end
            n_checks++; if (obs_bcd[i] !== nib(v, i / RD)) begin n_fail++; $display("FAIL scan_bcd[%0d]: got %h expected %h", i, obs_bcd[i], nib(v, i / RD)); end
            n_checks++; if (obs_blank[i] !== ((i % RD) < GD)) begin n_fail++; $display("FAIL scan_blank[%0d]: got %b expected %b", i, obs_blank[i], ((i % RD) < GD)); end
            n_checks++; if (obs_fd[i] !== (i == FRAME - 1)) begin n_fail++; $display("FAIL scan_fd[%0d]: got %b expected %b", i, obs_fd[i], (i == FRAME - 1)); end
        end
    endtask

    task automatic test_lz();
        logic [15:0] v;
        logic        eb;
        v = 16'h0050;
        lz_blank_en = 1'b1;
        scan_frame(0, v, -1, 16'h0);
        scan_frame(0, 16'h0000, -1, 16'h0);
        for (int i = 0; i < FRAME; i++) begin
            eb = ((i % RD) < GD) || (i / RD >= 2);
            n_checks++; if (obs_blank[i] !== eb) begin n_fail++; $display("FAIL lz50_blank[%0d]: got %b expected %b", i, obs_blank[i], eb); end
            n_checks++; if (obs_bcd[i] !== nib(v, i / RD)) begin n_fail++; $display("FAIL lz50_bcd[%0d]: got %h expected %h", i, obs_bcd[i], nib(v, i / RD)); end
            n_checks++; if (obs_an[i] !== exp_an(i)) begin n_fail++; $display("FAIL lz50_an[%0d]: got %b expected %b", i, obs_an[i], exp_an(i)); end
        end
        scan_frame(-1, 16'h0, -1, 16'h0);
        for (int i = 0; i < FRAME; i++) begin
            eb = ((i % RD) < GD) || (i / RD >= 1);
            n_checks++; if (obs_blank[i] !== eb) begin n_fail++; $display("FAIL lz00_blank[%0d]: got %b expected %b", i, obs_blank[i], eb); end
            n_checks++; if (obs_an[i] !== exp_an(i)) begin n_fail++; $display("FAIL lz00_an[%0d]: got %b expected %b", i, obs_an[i], exp_an(i)); end
        end
        lz_blank_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] vb;
        logic [15:0] vn;
        vb = 16'hBBBB;
        vn = 16'h5678;
        scan_frame(2, 16'hAAAA, 4, vb);
        for (int i = 0; i < FRAME; i++) begin
            n_checks++; if (obs_bcd[i] !== 4'h0) begin n_fail++; $display("FAIL b2b_hold_bcd[%0d]: got %h expected 0", i, obs_bcd[i]); end
        end
        scan_frame(3, 16'h9999, FRAME - 1, vn);
        for (int i = 0; i < FRAME; i++) begin
            n_checks++; if (obs_bcd[i] !== nib(vb, i / RD)) begin n_fail++; $display("FAIL b2b_last_bcd[%0d]: got %h expected %h", i, obs_bcd[i], nib(vb, i / RD)); end
            n_checks++; if (obs_an[i] !== exp_an(i)) begin n_fail++; $display("FAIL b2b_an[%0d]: got %b expected %b", i, obs_an[i], exp_an(i)); end
        end
        scan_frame(-1, 16'h0, -1, 16'h0);
        for (int i = 0; i < FRAME; i++) begin
            n_checks++; if (obs_bcd[i] !== nib(vn, i / RD)) begin n_fail++; $display("FAIL b2b_boundary_bcd[%0d]: got %h expected %h", i, obs_bcd[i], nib(vn, i / RD)); end
        end
    endtask

    task automatic test_enable();
        for (int i = 0; i < 10; i++) step();
        n_checks++; if (an_n !== 4'b1011) begin n_fail++; $display("FAIL en_pre_an: got %b expected 1011", an_n); end
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++; if (an_n !== 4'b1111 || blank !== 1'b1 || frame_done !== 1'b0) begin
                n_fail++; $display("FAIL en_off[%0d]: an=%b blank=%b fd=%b expected 1111/1/0", i, an_n, blank, frame_done);
            end
        end
        enable = 1'b1;
        step();
        n_checks++; if (an_n !== 4'b1011) begin n_fail++; $display("FAIL en_resume_an: got %b expected 1011", an_n); end
        n_checks++; if (bcd_out !== 4'h6) begin n_fail++; $display("FAIL en_resume_bcd: got %h expected 6", bcd_out); end
        n_checks++; if (blank !== 1'b0) begin n_fail++; $display("FAIL en_resume_blank: got %b expected 0", blank); end
        step();
        n_checks++; if (an_n !== 4'b1011) begin n_fail++; $display("FAIL en_cnt3_an: got %b expected 1011", an_n); end
        step();
        n_checks++; if (an_n !== 4'b1111) begin n_fail++; $display("FAIL en_guard3_an: got %b expected 1111", an_n); end
        step();
        n_checks++; if (an_n !== 4'b0111 || bcd_out !== 4'h5) begin n_fail++; $display("FAIL en_digit3: an=%b bcd=%h expected 0111/5", an_n, bcd_out); end
        step();
        step();
        n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL en_frame_done: got %b expected 1", frame_done); end
    endtask

    task automatic test_dp();
        logic ed;
        dp_in = 4'b0100;
        scan_frame(0, 16'h5678, -1, 16'h0);
        scan_frame(-1, 16'h0, -1, 16'h0);
        for (int i = 0; i < FRAME; i++) begin
            ed = ((i % RD) >= GD) && (i / RD == 2);
            n_checks++; if (obs_dp[i] !== ed) begin n_fail++; $display("FAIL dp[%0d]: got %b expected %b", i, obs_dp[i], ed); end
        end
        dp_in = 4'b0000;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) step();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (an_n !== 4'b1111) begin n_fail++; $display("FAIL rstmid_an: got %b expected 1111", an_n); end
        n_checks++; if (bcd_out !== 4'h0) begin n_fail++; $display("FAIL rstmid_bcd: got %h expected 0", bcd_out); end
        n_checks++; if (blank !== 1'b1 || dp_out !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_misc: blank=%b dp=%b fd=%b expected 1/0/0", blank, dp_out, frame_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_checks++; if (an_n !== 4'b1111) begin n_fail++; $display("FAIL rstmid_guard0: got %b expected 1111", an_n); end
        step();
        n_checks++; if (an_n !== 4'b1110 || bcd_out !== 4'h0) begin n_fail++; $display("FAIL rstmid_digit0: an=%b bcd=%h expected 1110/0", an_n, bcd_out); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_lz();
        test_back_to_back();
        test_enable();
        test_dp();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
